// File: rtl/dsadc_pkg.sv
// Shared types for the dual-slope ADC sequencer: FSM state encoding and error codes.
package dsadc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RST,
    INT,
    DEI,
    DONE
  } state_t;

  localparam logic [1:0] ERR_OK  = 2'd0;
  localparam logic [1:0] ERR_REF = 2'd1;
  localparam logic [1:0] ERR_OVR = 2'd2;
  localparam logic [1:0] ERR_SAT = 2'd3;

endpackage

// File: rtl/dsadc_sync.sv
// SYNC_N-deep synchroniser for the three asynchronous AFE status lines.
module dsadc_sync #(
  parameter int SYNC_N = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [2:0] d_i,
  output logic [2:0] q_o
);

  logic [2:0] stage [SYNC_N];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < SYNC_N; i++) stage[i] <= 3'b000;
    end else begin
      stage[0] <= d_i;
      for (int i = 1; i < SYNC_N; i++) stage[i] <= stage[i-1];
    end
  end

  assign q_o = stage[SYNC_N-1];

endmodule

// File: rtl/dual_slope_ctrl.sv
// Dual-slope ADC sequencer: reset, integrate, de-integrate and report a signed count.
// Optional feature: DSADC_AUTORANGE_EN enables one automatic range switch on saturation.
module dual_slope_ctrl
  import dsadc_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int CNT_W  = 16,
  parameter int T_INT  = 1024,
  parameter int T_RST  = 16,
  parameter int SYNC_N = 2,
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [CH_W-1:0]  ch_i,
  input  logic             range_i,
  output logic             busy_o,
  output logic [CH_W-1:0]  afe_sel_o,
  output logic             afe_reset_o,
  output logic             mode_sel_o,
  output logic             ref_sign_o,
  output logic             range_sel_o,
  input  logic             comp_i,
  input  logic             sat_hi_i,
  input  logic             sat_lo_i,
  input  logic             ref_ok_i,
  output logic             done_o,
  output logic [CNT_W-1:0] result_o,
  output logic             sign_o,
  output logic [CH_W-1:0]  ch_o,
  output logic             range_o,
  output logic [1:0]       err_o
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(T_RST - 1);
  localparam logic [CNT_W-1:0] INT_LAST = CNT_W'(T_INT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             pol;
  logic [2:0]       sync_q;
  logic             comp_s, sat_s, ref_ok_s;

  dsadc_sync #(.SYNC_N(SYNC_N)) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   ({comp_i, sat_hi_i | sat_lo_i, ref_ok_i}),
    .q_o   (sync_q)
  );

  assign {comp_s, sat_s, ref_ok_s} = sync_q;

  // Exit decisions that end a conversion, plus the autorange restart request.
  logic             fin;
  logic             restart;
  logic [1:0]       fin_err;
  logic [CNT_W-1:0] fin_res;
  logic             fin_sign;
  logic             sat_fail;

  always_comb begin
    fin      = 1'b0;
    restart  = 1'b0;
    fin_err  = ERR_OK;
    fin_res  = '0;
    fin_sign = 1'b0;
    sat_fail = 1'b0;
    if ((state == INT || state == DEI) && sat_s) begin
`ifdef DSADC_AUTORANGE_EN
      if (!range_sel_o) restart = 1'b1;
      else              sat_fail = 1'b1;
`else
      sat_fail = 1'b1;
`endif
    end
    case (state)
      IDLE: begin
        if (start_i && !ref_ok_s) begin
          fin     = 1'b1;
          fin_err = ERR_REF;
        end
      end
      INT: begin
        if (sat_fail) begin
          fin     = 1'b1;
          fin_err = ERR_SAT;
        end
      end
      DEI: begin
        if (!ref_ok_s) begin
          fin      = 1'b1;
          fin_err  = ERR_REF;
          fin_res  = cnt + 1'b1;
          fin_sign = pol;
        end else if (sat_fail) begin
          fin      = 1'b1;
          fin_err  = ERR_SAT;
        end else if (restart) begin
          fin      = 1'b0;
        end else if (comp_s != pol) begin
          fin      = 1'b1;
          fin_res  = cnt + 1'b1;
          fin_sign = pol;
        end else if (cnt == CNT_MAX - 1'b1) begin
          fin      = 1'b1;
          fin_err  = ERR_OVR;
          fin_res  = CNT_MAX;
          fin_sign = pol;
        end
      end
      default: begin
      end
    endcase
  end

  // Sequencer with every AFE control and result field registered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      pol         <= 1'b0;
      busy_o      <= 1'b0;
      afe_sel_o   <= '0;
      afe_reset_o <= 1'b1;
      mode_sel_o  <= 1'b0;
      ref_sign_o  <= 1'b0;
      range_sel_o <= 1'b0;
      done_o      <= 1'b0;
      result_o    <= '0;
      sign_o      <= 1'b0;
      ch_o        <= '0;
      range_o     <= 1'b0;
      err_o       <= ERR_OK;
    end else begin
      done_o <= 1'b0;
      if (fin) begin
        state       <= DONE;
        done_o      <= 1'b1;
        busy_o      <= 1'b1;
        afe_reset_o <= 1'b1;
        mode_sel_o  <= 1'b0;
        ref_sign_o  <= 1'b0;
        result_o    <= fin_res;
        sign_o      <= fin_sign;
        err_o       <= fin_err;
        ch_o        <= (state == IDLE) ? ch_i : afe_sel_o;
        range_o     <= (state == IDLE) ? range_i : range_sel_o;
        if (state == IDLE) begin
          afe_sel_o   <= ch_i;
          range_sel_o <= range_i;
        end
      end else if (restart) begin
        state       <= RST;
        cnt         <= '0;
        afe_reset_o <= 1'b1;
        mode_sel_o  <= 1'b0;
        ref_sign_o  <= 1'b0;
        range_sel_o <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (start_i) begin
              state       <= RST;
              busy_o      <= 1'b1;
              afe_sel_o   <= ch_i;
              range_sel_o <= range_i;
              afe_reset_o <= 1'b1;
              cnt         <= '0;
            end
          end
          RST: begin
            if (cnt == RST_LAST) begin
              state       <= INT;
              cnt         <= '0;
              afe_reset_o <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          INT: begin
            if (cnt == INT_LAST) begin
              state      <= DEI;
              cnt        <= '0;
              pol        <= comp_s;
              mode_sel_o <= 1'b1;
              ref_sign_o <= comp_s;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          DEI: begin
            cnt <= cnt + 1'b1;
          end
          DONE: begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dual_slope_ctrl.sv
// Directed bench for dual_slope_ctrl with a simple comparator model of the AFE.
// The autorange expectations follow DSADC_AUTORANGE_EN when the bench is built.
module tb_dual_slope_ctrl;

  localparam int NCH    = 4;
  localparam int CNT_W  = 8;
  localparam int T_INT  = 64;
  localparam int T_RST  = 4;
  localparam int SYNC_N = 2;
  localparam int NEVER  = 100000;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b0;
  logic             start_i = 1'b0;
  logic [1:0]       ch_i = 2'd0;
  logic             range_i = 1'b0;
  logic             busy_o;
  logic [1:0]       afe_sel_o;
  logic             afe_reset_o;
  logic             mode_sel_o;
  logic             ref_sign_o;
  logic             range_sel_o;
  logic             comp_i = 1'b0;
  logic             sat_hi_i = 1'b0;
  logic             sat_lo_i = 1'b0;
  logic             ref_ok_i = 1'b1;
  logic             done_o;
  logic [CNT_W-1:0] result_o;
  logic             sign_o;
  logic [1:0]       ch_o;
  logic             range_o;
  logic [1:0]       err_o;

  int numCompared = 0;
  int numMismatched = 0;
  bit modelPol = 1'b0;
  int modelK = NEVER;
  int deiCyc = 0;
  logic [1:0] deiSel;
  logic deiSign;
  bit sawInt;

  dual_slope_ctrl #(
    .NCH(NCH), .CNT_W(CNT_W), .T_INT(T_INT), .T_RST(T_RST), .SYNC_N(SYNC_N)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .ch_i(ch_i), .range_i(range_i),
    .busy_o(busy_o), .afe_sel_o(afe_sel_o), .afe_reset_o(afe_reset_o),
    .mode_sel_o(mode_sel_o), .ref_sign_o(ref_sign_o), .range_sel_o(range_sel_o),
    .comp_i(comp_i), .sat_hi_i(sat_hi_i), .sat_lo_i(sat_lo_i), .ref_ok_i(ref_ok_i),
    .done_o(done_o), .result_o(result_o), .sign_o(sign_o), .ch_o(ch_o),
    .range_o(range_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  // Comparator holds the input polarity and flips so the controller sees the
  // crossing in de-integrate cycle K, accounting for its SYNC_N input stages.
  always @(negedge clk_i) begin
    if (!mode_sel_o) begin
      deiCyc = 0;
      comp_i = modelPol;
    end else begin
      deiCyc = deiCyc + 1;
      if (deiCyc == modelK - SYNC_N) comp_i = ~modelPol;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    numCompared++;
    if (obs !== exp) begin
      numMismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int ch, input bit rng, input bit pol, input int k);
    modelPol = pol;
    modelK = k;
    repeat (4) @(negedge clk_i);
    ch_i = 2'(ch);
    range_i = rng;
    start_i = 1'b1;
  endtask

  task automatic waitDone(input int budget, input int satAt, input bit holdStart,
                          output int cyc, output bit ok);
    cyc = 1;
    ok = 1'b0;
    sawInt = 1'b0;
    deiSel = '0;
    deiSign = 1'b0;
    while (!ok && cyc < budget + 1) begin
      @(negedge clk_i);
      cyc++;
      if (cyc == 2 && !holdStart) start_i = 1'b0;
      if (satAt != 0 && cyc == satAt) sat_hi_i = 1'b1;
      if (satAt != 0 && cyc == satAt + 3) sat_hi_i = 1'b0;
      if (mode_sel_o) begin
        deiSel = afe_sel_o;
        deiSign = ref_sign_o;
      end
      if (busy_o && !afe_reset_o) sawInt = 1'b1;
      if (done_o) ok = 1'b1;
    end
    sat_hi_i = 1'b0;
  endtask

  int cyc;
  bit ok;
  int extra;

  initial begin
    #1 rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_afe_reset", afe_reset_o, 1);
    checkOutput("rst_done", done_o, 0);
    checkOutput("rst_mode", mode_sel_o, 0);
    checkOutput("rst_ref_sign", ref_sign_o, 0);
    checkOutput("rst_result", result_o, 0);
    checkOutput("rst_err", err_o, 0);
    checkOutput("rst_afe_sel", afe_sel_o, 0);
    rst_i = 1'b0;

    $display("[TB] test 1: ch 2, positive input, K=40");
    applyStimulus(2, 1'b0, 1'b1, 40);
    waitDone(400, 0, 1'b0, cyc, ok);
    checkOutput("t1_done_seen", ok, 1);
    checkOutput("t1_latency", cyc, 1 + T_RST + T_INT + 40 + 1);
    checkOutput("t1_result", result_o, 40);
    checkOutput("t1_sign", sign_o, 1);
    checkOutput("t1_err", err_o, 0);
    checkOutput("t1_ch", ch_o, 2);
    checkOutput("t1_afe_sel", deiSel, 2);
    checkOutput("t1_ref_sign", deiSign, 1);
    @(negedge clk_i);
    checkOutput("t1_done_pulse", done_o, 0);
    checkOutput("t1_busy_after", busy_o, 0);
    checkOutput("t1_result_held", result_o, 40);
    checkOutput("t1_afe_reset_idle", afe_reset_o, 1);

    $display("[TB] test 2: no crossing, overflow");
    applyStimulus(0, 1'b0, 1'b0, NEVER);
    waitDone(600, 0, 1'b0, cyc, ok);
    checkOutput("t2_done_seen", ok, 1);
    checkOutput("t2_latency", cyc, 1 + T_RST + T_INT + 255 + 1);
    checkOutput("t2_result", result_o, 255);
    checkOutput("t2_err", err_o, 2);
    extra = 0;
    repeat (20) begin
      @(negedge clk_i);
      if (done_o) extra++;
    end
    checkOutput("t2_extra_done", extra, 0);

    $display("[TB] test 3: reference not valid at start");
    ref_ok_i = 1'b0;
    repeat (4) @(negedge clk_i);
    applyStimulus(1, 1'b0, 1'b1, 40);
    waitDone(SYNC_N + 2, 0, 1'b0, cyc, ok);
    checkOutput("t3_done_seen", ok, 1);
    checkOutput("t3_fast", (cyc <= SYNC_N + 2) ? 1 : 0, 1);
    checkOutput("t3_err", err_o, 1);
    checkOutput("t3_no_int", sawInt, 0);
    ref_ok_i = 1'b1;
    repeat (4) @(negedge clk_i);

    $display("[TB] test 4: saturation during integrate, range 0");
    applyStimulus(1, 1'b0, 1'b1, 20);
    waitDone(400, 20, 1'b0, cyc, ok);
    checkOutput("t4_done_seen", ok, 1);
`ifdef DSADC_AUTORANGE_EN
    checkOutput("t4_err", err_o, 0);
    checkOutput("t4_range", range_o, 1);
    checkOutput("t4_result", result_o, 20);
`else
    checkOutput("t4_err", err_o, 3);
    checkOutput("t4_range", range_o, 0);
    checkOutput("t4_result", result_o, 0);
`endif

    $display("[TB] test 5: reset in de-integrate");
    applyStimulus(1, 1'b0, 1'b1, 40);
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (83) @(negedge clk_i);
    checkOutput("t5_in_dei", mode_sel_o, 1);
    #2 rst_i = 1'b1;
    #1;
    checkOutput("t5_busy", busy_o, 0);
    checkOutput("t5_afe_reset", afe_reset_o, 1);
    checkOutput("t5_mode", mode_sel_o, 0);
    checkOutput("t5_ref_sign", ref_sign_o, 0);
    checkOutput("t5_done", done_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    applyStimulus(3, 1'b0, 1'b0, 10);
    waitDone(400, 0, 1'b0, cyc, ok);
    checkOutput("t5_done_seen", ok, 1);
    checkOutput("t5_latency", cyc, 1 + T_RST + T_INT + 10 + 1);
    checkOutput("t5_result", result_o, 10);
    checkOutput("t5_sign", sign_o, 0);
    checkOutput("t5_ch", ch_o, 3);
    checkOutput("t5_err", err_o, 0);

    $display("[TB] test 6: start held through busy and done");
    applyStimulus(2, 1'b1, 1'b1, 30);
    waitDone(400, 0, 1'b1, cyc, ok);
    checkOutput("t6_done_seen", ok, 1);
    checkOutput("t6_latency", cyc, 1 + T_RST + T_INT + 30 + 1);
    checkOutput("t6_result", result_o, 30);
    checkOutput("t6_range", range_o, 1);
    @(negedge clk_i);
    start_i = 1'b0;
    extra = 0;
    repeat (150) begin
      @(negedge clk_i);
      if (done_o) extra++;
    end
    checkOutput("t6_extra_done", extra, 0);
    checkOutput("t6_idle_busy", busy_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
